ex_operand_sequencer: RTL

EX-stage operand sequencer of the RSA-decryption ASIP pipeline, consuming the forwarding selects from the hazard logic. It applies the RA/RB forward selects to choose each operand from the register file, EX/ME or ME/WB. For multi-cycle operations (modular multiply/exponent) it captures the selected operands, stalls the front of the pipeline, and runs a start/done handshake with the multi-cycle functional unit (FU). Captured operands remain valid after ME/WB drain, which is what makes the stall safe.

---
 rtl/ex_operand_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ex_operand_sequencer.sv
// EX-stage operand sequencer.
// Selects forwarded operands for the single-cycle ALU and, for multi-cycle
// operations, captures the operands, stalls the front of the pipeline and
// runs a start/done handshake with the multi-cycle functional unit.
// The captured operands stay valid after the ME/WB stage drains, which is
// what allows the pipeline front to be frozen safely for the whole operation.
module ex_operand_sequencer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        forward_RA,
    input  logic [1:0]        forward_RB,
    input  logic [DATA_W-1:0] rf_a,
    input  logic [DATA_W-1:0] rf_b,
    input  logic [DATA_W-1:0] alu_me,
    input  logic [DATA_W-1:0] res_wb,
    input  logic              in_valid,
    input  logic              in_multi,
    input  logic              flush,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] fu_a,
    output logic [DATA_W-1:0] fu_b,
    output logic              fu_start,
    input  logic              fu_ready,
    input  logic              fu_done,
    input  logic [DATA_W-1:0] fu_result,
    output logic              stall,
    output logic              result_valid,
    output logic [DATA_W-1:0] mul_result
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_cap_a;
    logic [DATA_W-1:0] r_cap_b;
    logic [DATA_W-1:0] r_mul_result;

    logic [DATA_W-1:0] w_sel_a;
    logic [DATA_W-1:0] w_sel_b;
    logic              w_is_idle;
    logic              w_launch;
    logic              w_busy;

    // Forwarding mux for operand A: encoding 11 falls back to the register file.
    always_comb begin
        w_sel_a = rf_a;
        case (forward_RA)
            2'b01:   w_sel_a = alu_me;
            2'b10:   w_sel_a = res_wb;
            default: w_sel_a = rf_a;
        endcase
    end

    // Forwarding mux for operand B, same encoding as operand A.
    always_comb begin
        w_sel_b = rf_b;
        case (forward_RB)
            2'b01:   w_sel_b = alu_me;
            2'b10:   w_sel_b = res_wb;
            default: w_sel_b = rf_b;
        endcase
    end

    assign w_is_idle = (r_state == S_IDLE);
    // A multi-cycle instruction must freeze the front in the very cycle it is
    // seen, before the FSM has left IDLE, hence the combinational launch term.
    assign w_launch  = w_is_idle & in_valid & in_multi & ~flush;
    assign w_busy    = (r_state == S_ISSUE) | (r_state == S_WAIT) | (r_state == S_DRAIN);

    // Outside IDLE the ALU sees the captured operands, since the forwarding
    // sources may have drained while the pipeline front is frozen.
    assign op_a         = w_is_idle ? w_sel_a : r_cap_a;
    assign op_b         = w_is_idle ? w_sel_b : r_cap_b;
    assign fu_a         = r_cap_a;
    assign fu_b         = r_cap_b;
    assign fu_start     = (r_state == S_ISSUE) & fu_ready & ~flush;
    assign stall        = ~rst & (w_launch | w_busy);
    assign result_valid = (r_state == S_DONE);
    assign mul_result   = r_mul_result;

    // Sequencer FSM: operand capture, FU handshake, flush drain and result latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cap_a      <= {DATA_W{1'b0}};
            r_cap_b      <= {DATA_W{1'b0}};
            r_mul_result <= {DATA_W{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_cap_a <= w_sel_a;
                        r_cap_b <= w_sel_b;
                        r_state <= S_ISSUE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else if (fu_ready) begin
                        r_state <= S_WAIT;
                    end else begin
                        r_state <= S_ISSUE;
                    end
                end
                S_WAIT: begin
                    if (fu_done && !flush) begin
                        r_mul_result <= fu_result;
                        r_state      <= S_DONE;
                    end else if (flush && !fu_done) begin
                        r_state <= S_DRAIN;
                    end else if (flush && fu_done) begin
                        // Squashed instruction whose result arrives now: drop it.
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_DRAIN: begin
                    // The FU cannot be aborted; swallow its result when it comes.
                    if (fu_done) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
